// File: rtl/sigdel_adc_decim.sv
// CIC decimator that turns a 1-bit sigma-delta stream into signed PCM samples,
// followed by an arithmetic rescale and saturation to the output width.
module sigdel_adc_decim #(
    parameter int OSR    = 1024,
    parameter int CIC    = 2,
    parameter int BITLEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in,
    output logic [BITLEN-1:0] out,
    output logic              out_valid,
    output logic              clip
);
    localparam int LOG2  = $clog2(OSR);
    localparam int ACC_W = 2 + CIC * LOG2;
    localparam int SHIFT = CIC * LOG2 - (BITLEN - 1);
    localparam int HI_W  = ACC_W - BITLEN + 1;

    logic [ACC_W-1:0]        w_x;
    logic [ACC_W-1:0]        r_integ     [CIC];
    logic [ACC_W-1:0]        w_integNext [CIC];
    logic [LOG2-1:0]         r_count;
    logic                    w_lastBit;
    logic [ACC_W-1:0]        r_combIn;
    logic                    r_capValid;
    logic [ACC_W-1:0]        r_delay     [CIC];
    logic [ACC_W-1:0]        w_comb      [CIC];
    logic [ACC_W-1:0]        r_combOut;
    logic                    r_combValid;
    logic signed [ACC_W-1:0] w_shifted;
    logic [HI_W-1:0]         w_hi;
    logic                    w_sat;
    logic [BITLEN-1:0]       w_satVal;

    assign w_x       = in ? ACC_W'(1) : {ACC_W{1'b1}};
    assign w_lastBit = ena && (r_count == LOG2'(OSR - 1));

    // Each integrator adds the freshly updated value of the stage before it,
    // so the captured sum already includes the window's final bit.
    always_comb begin
        w_integNext[0] = r_integ[0] + w_x;
        for (int k = 1; k < CIC; k++) begin
            w_integNext[k] = r_integ[k] + w_integNext[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CIC; k++) begin
                r_integ[k] <= '0;
            end
            r_count    <= '0;
            r_combIn   <= '0;
            r_capValid <= 1'b0;
        end else begin
            r_capValid <= w_lastBit;
            if (ena) begin
                for (int k = 0; k < CIC; k++) begin
                    r_integ[k] <= w_integNext[k];
                end
                r_count <= r_count + LOG2'(1);
            end
            if (w_lastBit) begin
                r_combIn <= w_integNext[CIC-1];
            end
        end
    end

    always_comb begin
        w_comb[0] = r_combIn - r_delay[0];
        for (int k = 1; k < CIC; k++) begin
            w_comb[k] = w_comb[k-1] - r_delay[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CIC; k++) begin
                r_delay[k] <= '0;
            end
            r_combOut   <= '0;
            r_combValid <= 1'b0;
        end else begin
            r_combValid <= r_capValid;
            if (r_capValid) begin
                r_delay[0] <= r_combIn;
                for (int k = 1; k < CIC; k++) begin
                    r_delay[k] <= w_comb[k-1];
                end
                r_combOut <= w_comb[CIC-1];
            end
        end
    end

    // Out of range exactly when the bits above the output sign bit disagree.
    assign w_shifted = $signed(r_combOut) >>> SHIFT;
    assign w_hi      = w_shifted[ACC_W-1:BITLEN-1];
    assign w_sat     = !((&w_hi) || !(|w_hi));
    assign w_satVal  = w_shifted[ACC_W-1] ? {1'b1, {(BITLEN-1){1'b0}}}
                                          : {1'b0, {(BITLEN-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            clip      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_combValid;
            if (r_combValid) begin
                out  <= w_sat ? w_satVal : w_shifted[BITLEN-1:0];
                clip <= w_sat;
            end
        end
    end
endmodule

// File: tb/tb_sigdel_adc_decim.sv
// Bench for sigdel_adc_decim: default and small-parameter instances, expected
// samples from windowed cumulative sums and finite differences in plain arithmetic.
module tb_sigdel_adc_decim;
    typedef struct {
        int val;
        bit clp;
        int at;
    } pulse_t;

    logic clk = 1'b0;
    logic rst;
    logic ena, inBit;
    logic [15:0] out;
    logic outValid, clip;
    logic enaS, inS;
    logic [11:0] outS;
    logic validS, clipS;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    pulse_t obsBig[$];
    pulse_t obsSmall[$];
    int xs[$];
    int xsAt[$];
    int xsS[$];
    int xsSAt[$];
    int expVal[$];
    bit expClip[$];

    always #5 clk = ~clk;

    sigdel_adc_decim #(.OSR(1024), .CIC(2), .BITLEN(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in(inBit),
        .out(out), .out_valid(outValid), .clip(clip)
    );

    sigdel_adc_decim #(.OSR(16), .CIC(3), .BITLEN(12)) dutSmall (
        .clk(clk), .rst(rst), .ena(enaS), .in(inS),
        .out(outS), .out_valid(validS), .clip(clipS)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (outValid === 1'b1) obsBig.push_back('{int'($signed(out)), clip, cyc});
        if (validS === 1'b1) obsSmall.push_back('{int'($signed(outS)), clipS, cyc});
    end

    // Expected samples: k-fold running sums sampled at window ends, then the
    // k-th backward difference, wrapped to the accumulator width, scaled, clamped.
    function automatic void runModel(input int x[$], input int osr, input int cic, input int bitlen);
        longint s[4];
        longint samp[$];
        longint modv, c, v, y, maxV, minV;
        int lg, accw, shift, coef;
        lg = 0;
        while ((1 << lg) < osr) lg++;
        accw  = 2 + cic * lg;
        shift = cic * lg - (bitlen - 1);
        expVal.delete();
        expClip.delete();
        for (int k = 0; k < 4; k++) s[k] = 0;
        for (int n = 0; n < x.size(); n++) begin
            s[0] += x[n];
            for (int k = 1; k < cic; k++) s[k] += s[k-1];
            if ((n + 1) % osr == 0) samp.push_back(s[cic-1]);
        end
        modv = longint'(1) << accw;
        maxV = (longint'(1) << (bitlen - 1)) - 1;
        minV = -maxV - 1;
        for (int m = 0; m < samp.size(); m++) begin
            c = 0;
            coef = 1;
            for (int j = 0; j <= cic; j++) begin
                if (m - j >= 0) c += longint'((j % 2) ? -coef : coef) * samp[m-j];
                coef = coef * (cic - j) / (j + 1);
            end
            v = c % modv;
            if (v < 0) v += modv;
            if (v >= modv / 2) v -= modv;
            y = v >>> shift;
            expClip.push_back(y > maxV || y < minV);
            expVal.push_back(int'(y > maxV ? maxV : (y < minV ? minV : y)));
        end
    endfunction

    task automatic stepBig(input bit e, input bit b);
        @(negedge clk);
        ena = e;
        inBit = b;
        if (e) begin
            xs.push_back(b ? 1 : -1);
            xsAt.push_back(cyc);
        end
    endtask

    task automatic stepSmall(input bit e, input bit b);
        @(negedge clk);
        enaS = e;
        inS = b;
        if (e) begin
            xsS.push_back(b ? 1 : -1);
            xsSAt.push_back(cyc);
        end
    endtask

    task automatic clearRecords();
        xs.delete(); xsAt.delete(); xsS.delete(); xsSAt.delete();
        obsBig.delete(); obsSmall.delete();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; ena = 1'b0; inBit = 1'b0; enaS = 1'b0; inS = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearRecords();
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; inBit = 1'b1; enaS = 1'b1; inS = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (out !== 16'd0 || outValid !== 1'b0 || clip !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_big: out=%0d valid=%b clip=%b required 0/0/0", out, outValid, clip);
        end
        nChecks++;
        if (outS !== 12'd0 || validS !== 1'b0 || clipS !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_small: out=%0d valid=%b clip=%b required 0/0/0", outS, validS, clipS);
        end
    endtask

    task automatic test_const_high();
        applyReset();
        for (int n = 0; n < 4 * 1024; n++) stepBig(1'b1, 1'b1);
        repeat (8) stepBig(1'b0, 1'b0);
        runModel(xs, 1024, 2, 16);
        nChecks++;
        if (obsBig.size() !== expVal.size()) begin
            nFails++;
            $display("[TB] FAIL constHigh count: got %0d required %0d", obsBig.size(), expVal.size());
        end
        for (int i = 0; i < obsBig.size() && i < expVal.size(); i++) begin
            nChecks++;
            if (obsBig[i].val !== expVal[i] || obsBig[i].clp !== expClip[i] || obsBig[i].at !== xsAt[(i+1)*1024-1] + 3) begin
                nFails++;
                $display("[TB] FAIL constHigh pulse%0d: out=%0d clip=%b at=%0d required %0d/%b/%0d", i, obsBig[i].val,
                         obsBig[i].clp, obsBig[i].at, expVal[i], expClip[i], xsAt[(i+1)*1024-1] + 3);
            end
        end
        if (obsBig.size() >= 2) begin
            nChecks++;
            if (obsBig[0].val !== 16400 || obsBig[0].clp !== 1'b0 || obsBig[1].val !== 32767 || obsBig[1].clp !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL constHigh known: p1=%0d/%b p2=%0d/%b required 16400/0 32767/1",
                         obsBig[0].val, obsBig[0].clp, obsBig[1].val, obsBig[1].clp);
            end
        end
    endtask

    task automatic test_const_low();
        applyReset();
        for (int n = 0; n < 3 * 1024; n++) stepBig(1'b1, 1'b0);
        repeat (8) stepBig(1'b0, 1'b0);
        runModel(xs, 1024, 2, 16);
        nChecks++;
        if (obsBig.size() !== expVal.size()) begin
            nFails++;
            $display("[TB] FAIL constLow count: got %0d required %0d", obsBig.size(), expVal.size());
        end
        for (int i = 0; i < obsBig.size() && i < expVal.size(); i++) begin
            nChecks++;
            if (obsBig[i].val !== expVal[i] || obsBig[i].clp !== expClip[i] || obsBig[i].at !== xsAt[(i+1)*1024-1] + 3) begin
                nFails++;
                $display("[TB] FAIL constLow pulse%0d: out=%0d clip=%b at=%0d required %0d/%b/%0d", i, obsBig[i].val,
                         obsBig[i].clp, obsBig[i].at, expVal[i], expClip[i], xsAt[(i+1)*1024-1] + 3);
            end
        end
        if (obsBig.size() >= 2) begin
            nChecks++;
            if (obsBig[0].val !== -16400 || obsBig[1].val !== -32768 || obsBig[1].clp !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL constLow known: p1=%0d p2=%0d/%b required -16400 -32768/0",
                         obsBig[0].val, obsBig[1].val, obsBig[1].clp);
            end
        end
    endtask

    task automatic test_alternating();
        applyReset();
        for (int n = 0; n < 3 * 1024; n++) stepBig(1'b1, (n % 2) == 0);
        repeat (8) stepBig(1'b0, 1'b0);
        runModel(xs, 1024, 2, 16);
        nChecks++;
        if (obsBig.size() !== expVal.size()) begin
            nFails++;
            $display("[TB] FAIL alternating count: got %0d required %0d", obsBig.size(), expVal.size());
        end
        for (int i = 0; i < obsBig.size() && i < expVal.size(); i++) begin
            nChecks++;
            if (obsBig[i].val !== expVal[i] || obsBig[i].clp !== expClip[i] || (i > 0 && obsBig[i].val !== 0)) begin
                nFails++;
                $display("[TB] FAIL alternating pulse%0d: out=%0d clip=%b required %0d/%b", i, obsBig[i].val,
                         obsBig[i].clp, expVal[i], expClip[i]);
            end
        end
    endtask

    task automatic test_random_stream();
        applyReset();
        while (xs.size() < 4 * 1024) stepBig(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (8) stepBig(1'b0, 1'b0);
        runModel(xs, 1024, 2, 16);
        nChecks++;
        if (obsBig.size() !== expVal.size()) begin
            nFails++;
            $display("[TB] FAIL random count: got %0d required %0d", obsBig.size(), expVal.size());
        end
        for (int i = 0; i < obsBig.size() && i < expVal.size(); i++) begin
            nChecks++;
            if (obsBig[i].val !== expVal[i] || obsBig[i].clp !== expClip[i] || obsBig[i].at !== xsAt[(i+1)*1024-1] + 3) begin
                nFails++;
                $display("[TB] FAIL random pulse%0d: out=%0d clip=%b at=%0d required %0d/%b/%0d", i, obsBig[i].val,
                         obsBig[i].clp, obsBig[i].at, expVal[i], expClip[i], xsAt[(i+1)*1024-1] + 3);
            end
        end
    endtask

    task automatic test_sparse_ena();
        applyReset();
        for (int n = 0; n < 3 * 1024 * 4; n++) begin
            stepBig((n % 4) == 3, 1'b1);
            if (n == (1024 + 512) * 4) begin
                nChecks++;
                if (out !== 16'd16400 || clip !== 1'b0 || outValid !== 1'b0) begin
                    nFails++;
                    $display("[TB] FAIL sparse holdMid: out=%0d clip=%b valid=%b required 16400/0/0", $signed(out), clip, outValid);
                end
            end
        end
        repeat (50) stepBig(1'b0, 1'b0);
        runModel(xs, 1024, 2, 16);
        nChecks++;
        if (obsBig.size() !== expVal.size()) begin
            nFails++;
            $display("[TB] FAIL sparse count: got %0d required %0d", obsBig.size(), expVal.size());
        end
        for (int i = 0; i < obsBig.size() && i < expVal.size(); i++) begin
            nChecks++;
            if (obsBig[i].val !== expVal[i] || obsBig[i].clp !== expClip[i] || obsBig[i].at !== xsAt[(i+1)*1024-1] + 3) begin
                nFails++;
                $display("[TB] FAIL sparse pulse%0d: out=%0d clip=%b at=%0d required %0d/%b/%0d", i, obsBig[i].val,
                         obsBig[i].clp, obsBig[i].at, expVal[i], expClip[i], xsAt[(i+1)*1024-1] + 3);
            end
        end
        if (expVal.size() > 0) begin
            nChecks++;
            if (int'($signed(out)) !== expVal[expVal.size()-1] || clip !== expClip[expClip.size()-1] || outValid !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL sparse holdEnd: out=%0d clip=%b required %0d/%b", $signed(out), clip,
                         expVal[expVal.size()-1], expClip[expClip.size()-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        applyReset();
        for (int n = 0; n < 1500; n++) stepBig(1'b1, 1'b1);
        runModel(xs, 1024, 2, 16);
        nChecks++;
        if (obsBig.size() !== expVal.size() || (obsBig.size() > 0 && obsBig[0].val !== expVal[0])) begin
            nFails++;
            $display("[TB] FAIL resetMid before: pulses=%0d required %0d", obsBig.size(), expVal.size());
        end
        @(negedge clk);
        ena = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nChecks++;
            if (out !== 16'd0 || outValid !== 1'b0 || clip !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL resetMid during%0d: out=%0d valid=%b clip=%b required 0/0/0", k, out, outValid, clip);
            end
        end
        rst = 1'b0;
        clearRecords();
        for (int n = 0; n < 1100; n++) stepBig(1'b1, 1'b1);
        repeat (8) stepBig(1'b0, 1'b0);
        nChecks++;
        if (obsBig.size() !== 1) begin
            nFails++;
            $display("[TB] FAIL resetMid after count: got %0d required 1", obsBig.size());
        end else begin
            nChecks++;
            if (obsBig[0].val !== 16400 || obsBig[0].clp !== 1'b0 || obsBig[0].at !== xsAt[1023] + 3) begin
                nFails++;
                $display("[TB] FAIL resetMid after pulse: out=%0d clip=%b at=%0d required 16400/0/%0d",
                         obsBig[0].val, obsBig[0].clp, obsBig[0].at, xsAt[1023] + 3);
            end
        end
    endtask

    task automatic test_small_params();
        applyReset();
        for (int n = 0; n < 30000; n++) stepSmall(1'b1, 1'b1);
        repeat (8) stepSmall(1'b0, 1'b0);
        runModel(xsS, 16, 3, 12);
        nChecks++;
        if (obsSmall.size() !== expVal.size()) begin
            nFails++;
            $display("[TB] FAIL small count: got %0d required %0d", obsSmall.size(), expVal.size());
        end
        for (int i = 0; i < obsSmall.size() && i < expVal.size(); i++) begin
            nChecks++;
            if (obsSmall[i].val !== expVal[i] || obsSmall[i].clp !== expClip[i] || obsSmall[i].at !== xsSAt[(i+1)*16-1] + 3) begin
                nFails++;
                $display("[TB] FAIL small pulse%0d: out=%0d clip=%b at=%0d required %0d/%b/%0d", i, obsSmall[i].val,
                         obsSmall[i].clp, obsSmall[i].at, expVal[i], expClip[i], xsSAt[(i+1)*16-1] + 3);
            end
        end
        if (obsSmall.size() >= 3) begin
            nChecks++;
            if (obsSmall[0].val !== 408 || obsSmall[2].val !== 2047 || obsSmall[2].clp !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL small known: p1=%0d p3=%0d/%b required 408 2047/1",
                         obsSmall[0].val, obsSmall[2].val, obsSmall[2].clp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_high();
        test_const_low();
        test_alternating();
        test_random_stream();
        test_sparse_ena();
        test_reset_mid();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
